// File: rtl/rf_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared definitions for the register-file writeback arbiter:
//   - XLEN encodings (2-bit) and the derived data width helper
//   - arbiter FSM state type
//   - default starvation limit
// Optional feature macro used by the arbiter: RF_WB_ARB_PERF_EN
// -----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

   // XLEN encodings; the data width is 1 << (XLEN + 4).
   localparam logic [1:0] XLEN_32B  = 2'd1;
   localparam logic [1:0] XLEN_64B  = 2'd2;
   localparam logic [1:0] XLEN_128B = 2'd3;

   localparam int DEFAULT_STARVE_LIMIT = 4;

   typedef enum logic {
      S_PRIO0  = 1'b0,   // port 0 has priority
      S_FORCE1 = 1'b1    // port 0 stalled, port 1 granted
   } arb_state_e;

   function automatic int data_width(input logic [1:0] xlen);
      return 1 << (int'(xlen) + 4);
   endfunction

endpackage

// File: rtl/rf_wb_starve_ctr.sv
// -----------------------------------------------------------------------------
// rf_wb_starve_ctr
// Counts consecutive cycles in which a valid port-1 request is denied and
// raises force_req on the cycle the count reaches STARVE_LIMIT, so the
// arbiter FSM can move to its forced-grant state on the next edge.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   enable          global clock enable; low = counter holds
//   p1_valid        port-1 request
//   p1_ready        port-1 grant this cycle
//   force_req       denied request that brings the count to the limit
// -----------------------------------------------------------------------------
module rf_wb_starve_ctr #(
   parameter int STARVE_LIMIT = 4     // legal range 1..15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic enable,
   input  logic p1_valid,
   input  logic p1_ready,
   output logic force_req
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve;
   logic       denied;

   assign denied = enable & p1_valid & ~p1_ready;

   // The count is one short of the limit, so this denial reaches it.
   assign force_req = denied & (starve >= LIMIT - 4'd1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         starve <= 4'd0;
      end else if (enable) begin
         if (!p1_valid || p1_ready) begin
            // Idle port 1 or a completed handshake ends the wait.
            starve <= 4'd0;
         end else if (starve < LIMIT) begin
            starve <= starve + 4'd1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Arbitrates the single register-file write port between the in-order WB
// stage (port 0, fixed priority) and the long-latency unit return (port 1).
// A starvation guard forces a port-1 grant after STARVE_LIMIT consecutive
// denied cycles. The winning request is registered and drives the register
// file write port directly; the same registers are exposed as the in-flight
// write for hazard logic.
// Parameters:
//   XLEN          2-bit encoding, data width DW = 1 << (XLEN + 4)
//   STARVE_LIMIT  denied cycles before a forced port-1 grant (1..15)
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_clk_enable                  global stall, low = all state holds
//   i_p0_valid/addr/data, o_p0_ready   port-0 write request
//   i_p1_valid/addr/data, o_p1_ready   port-1 write request
//   o_rf_we/o_rf_wr_addr/o_rf_wr_data  registered register-file write
//   o_pend_valid/o_pend_addr           in-flight write (same registers)
// Optional (macro RF_WB_ARB_PERF_EN):
//   o_perf_conflicts   enabled cycles with both requests valid
//   o_perf_forced      number of entries into the forced-grant state
// -----------------------------------------------------------------------------
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter logic [1:0] XLEN         = XLEN_64B,
   parameter int         STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   localparam int        DW           = data_width(XLEN)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clk_enable,
   input  logic          i_p0_valid,
   input  logic [4:0]    i_p0_addr,
   input  logic [DW-1:0] i_p0_data,
   output logic          o_p0_ready,
   input  logic          i_p1_valid,
   input  logic [4:0]    i_p1_addr,
   input  logic [DW-1:0] i_p1_data,
   output logic          o_p1_ready,
   output logic          o_rf_we,
   output logic [4:0]    o_rf_wr_addr,
   output logic [DW-1:0] o_rf_wr_data,
   output logic          o_pend_valid,
   output logic [4:0]    o_pend_addr
`ifdef RF_WB_ARB_PERF_EN
   ,
   output logic [31:0]   o_perf_conflicts,
   output logic [31:0]   o_perf_forced
`endif
);

   arb_state_e state, state_next;
   logic       p0_fire, p1_fire;
   logic       force_req;

   // Readies never look at their own valid; port 1 only sees port 0's valid,
   // which keeps both readies from being high while both valids are high.
   assign o_p0_ready = i_clk_enable & ~i_rst & (state == S_PRIO0);
   assign o_p1_ready = i_clk_enable & ~i_rst & ((state == S_FORCE1) | ~i_p0_valid);

   assign p0_fire = i_p0_valid & o_p0_ready;
   assign p1_fire = i_p1_valid & o_p1_ready;

   rf_wb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .enable    (i_clk_enable),
      .p1_valid  (i_p1_valid),
      .p1_ready  (o_p1_ready),
      .force_req (force_req)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_PRIO0;
      end else if (i_clk_enable) begin
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: every comb output gets a default before the case so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_next = state;
      case (state)
         S_PRIO0: begin
            if (force_req) state_next = S_FORCE1;
         end
         S_FORCE1: begin
            // Leave on the granted handshake; a dropped request is only
            // recovered from, never expected.
            if (i_clk_enable && (p1_fire || !i_p1_valid)) state_next = S_PRIO0;
         end
         default: state_next = S_PRIO0;
      endcase
   end

   // Registered write command. A handshake to x0 is still captured for
   // debug visibility but never asserts the write enable.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rf_we      <= 1'b0;
         o_rf_wr_addr <= 5'd0;
         o_rf_wr_data <= '0;
      end else if (i_clk_enable) begin
         if (p0_fire) begin
            o_rf_we      <= (i_p0_addr != 5'd0);
            o_rf_wr_addr <= i_p0_addr;
            o_rf_wr_data <= i_p0_data;
         end else if (p1_fire) begin
            o_rf_we      <= (i_p1_addr != 5'd0);
            o_rf_wr_addr <= i_p1_addr;
            o_rf_wr_data <= i_p1_data;
         end else begin
            // A write held through a stall commits exactly once: it clears
            // on the first enabled cycle without a new handshake.
            o_rf_we <= 1'b0;
         end
      end
   end

   assign o_pend_valid = o_rf_we;
   assign o_pend_addr  = o_rf_wr_addr;

`ifdef RF_WB_ARB_PERF_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_perf_conflicts <= 32'd0;
         o_perf_forced    <= 32'd0;
      end else if (i_clk_enable) begin
         if (i_p0_valid && i_p1_valid) o_perf_conflicts <= o_perf_conflicts + 32'd1;
         if (state == S_PRIO0 && state_next == S_FORCE1) o_perf_forced <= o_perf_forced + 32'd1;
      end
   end
`endif

endmodule
